// File: rtl/fetch_stage.sv
// Instruction fetch front end: word-aligned reads feed a halfword prefetch
// buffer, from which 16/32-bit (RVC) instructions are aligned and handed to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0,
    parameter int          BUF_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_exception,
    output logic [3:0]  f_ecause,
    output logic [31:0] f_etval
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int BW = 16 * BUF_DEPTH;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          req_valid_q, req_valid_d;
    logic [31:0]   fault_addr_q, fault_addr_d;
    logic          ecause_q, ecause_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] hw_q, hw_d;
    logic          drop_q, drop_d;
    logic          half_q, half_d;
    logic          redir_q, redir_d;

    logic          head_is32;
    logic          instr_avail;
    logic          show_fault;
    logic          consume;
    logic          resp;
    logic          outstanding;
    logic [CW-1:0] pop_n, push_n, keep_n;
    logic [BW-1:0] hw_kept, wdata;
    logic [31:0]   instr_word;

    // Buffer is a flat halfword shift register: head at bits [15:0], slots above count are zero.
    always_comb begin
        head_is32   = (hw_q[1:0] == 2'b11);
        instr_avail = head_is32 ? (count_q >= CW'(2)) : (count_q != '0);
        // Instructions fetched before the fault are delivered first; the fault then follows.
        show_fault  = (state_q == S_FAULT) && !instr_avail && !redir_q;
        instr_word  = head_is32 ? hw_q[31:0] : {16'h0, hw_q[15:0]};
        f_valid     = instr_avail || show_fault;
        f_exception = show_fault;
        f_ecause    = show_fault ? {3'b000, ecause_q} : 4'h0;
        f_etval     = show_fault ? fault_addr_q : 32'h0;
        f_pc        = instr_avail ? pc_q : f_etval;
        f_instr     = instr_avail ? instr_word : 32'h0;
        consume     = instr_avail && !stall && !redirect;
        imem_valid  = req_valid_q;
        imem_addr   = req_addr_q;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        req_valid_d  = req_valid_q;
        fault_addr_d = fault_addr_q;
        ecause_d     = ecause_q;
        drop_d       = drop_q;
        half_d       = half_q;
        redir_d      = redirect;
        resp         = req_valid_q && imem_ready;
        outstanding  = req_valid_q && !imem_ready;
        pop_n        = consume ? (head_is32 ? CW'(2) : CW'(1)) : '0;
        push_n       = '0;
        wdata        = '0;
        wdata[31:0]  = half_q ? {16'h0, imem_rdata[31:16]} : imem_rdata;

        if (consume) begin
            pc_d = pc_q + (head_is32 ? 32'd4 : 32'd2);
        end
        if (resp) begin
            req_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (count_q <= CW'(BUF_DEPTH - 2)) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = fetch_addr_q;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp) begin
                    state_d = S_FETCH;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (imem_error) begin
                        state_d      = S_FAULT;
                        ecause_d     = 1'b1;
                        fault_addr_d = req_addr_q;
                    end else begin
                        push_n       = half_q ? CW'(1) : CW'(2);
                        half_d       = 1'b0;
                        fetch_addr_d = fetch_addr_q + 32'd4;
                    end
                end
            end
            default: ;
        endcase

        keep_n  = count_q - pop_n;
        hw_kept = hw_q >> {pop_n, 4'b0000};
        hw_d    = (push_n != '0) ? (hw_kept | (wdata << {keep_n, 4'b0000})) : hw_kept;
        count_d = keep_n + push_n;

        // A request already on the bus must still complete; its data is dropped via drop_q.
        if (redirect) begin
            pc_d         = redirect_addr;
            fetch_addr_d = {redirect_addr[31:2], 2'b00};
            count_d      = '0;
            hw_d         = '0;
            half_d       = redirect_addr[1];
            req_addr_d   = req_addr_q;
            req_valid_d  = outstanding;
            if (redirect_addr[0]) begin
                state_d      = S_FAULT;
                ecause_d     = 1'b0;
                fault_addr_d = redirect_addr;
                drop_d       = 1'b0;
            end else if (outstanding) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = S_FETCH;
                drop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_ADDR;
            fetch_addr_q <= {RESET_ADDR[31:2], 2'b00};
            req_addr_q   <= 32'h0;
            req_valid_q  <= 1'b0;
            fault_addr_q <= 32'h0;
            ecause_q     <= 1'b0;
            count_q      <= '0;
            hw_q         <= '0;
            drop_q       <= 1'b0;
            half_q       <= RESET_ADDR[1];
            redir_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            req_valid_q  <= req_valid_d;
            fault_addr_q <= fault_addr_d;
            ecause_q     <= ecause_d;
            count_q      <= count_d;
            hw_q         <= hw_d;
            drop_q       <= drop_d;
            half_q       <= half_d;
            redir_q      <= redir_d;
        end
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end stage directly upstream of decode.
- Issues word-aligned instruction reads on a valid/ready memory interface and keeps a halfword prefetch buffer.
- Aligns mixed 16/32-bit (RVC) instructions and presents one instruction per cycle with its pc and any fetch exception.
- Decode consumes it through stall and redirects it on jump/exception/mret.

Parameters:
- RESET_ADDR, 32'h0, pc after reset.
- BUF_DEPTH, 4, prefetch buffer capacity in halfwords (even, ≥4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_valid  out  1  read request valid
- imem_addr  out  32  request address, bits[1:0]=0
- imem_ready  in  1  response/accept strobe for the outstanding request
- imem_rdata  in  32  read data, valid with imem_ready
- imem_error  in  1  access fault, valid with imem_ready
- redirect  in  1  flush and restart fetch
- redirect_addr  in  32  new pc
- stall  in  1  decode not consuming this cycle
- f_valid  out  1  f_* fields hold an instruction or exception
- f_pc  out  32  instruction pc
- f_instr  out  32  instruction; 16-bit forms zero-extended in [31:16]
- f_exception  out  1  fetch exception
- f_ecause  out  4  0 = misaligned, 1 = access fault
- f_etval  out  32  faulting address

Behaviour:
- Reset (async, while rst=1):
  - State FETCH, pc=RESET_ADDR, fetch_addr=RESET_ADDR&~3.
  - Buffer count=0, drop=0.
  - All outputs 0.
- Memory protocol:
  - At most one outstanding request.
  - imem_valid and imem_addr are registered and held stable until imem_ready.
  - imem_ready in the same cycle as imem_valid rise is not possible; earliest response is the next cycle.
- FSM:
  - FETCH: if count ≤ BUF_DEPTH-2, assert imem_valid and go to WAIT; otherwise stay in FETCH.
  - WAIT, on imem_ready:
    - drop=1: discard the response, clear drop, go to FETCH.
    - imem_error=1: go to FAULT with etval=imem_addr.
    - Otherwise: write the halfwords and go to FETCH with fetch_addr += 4.
  - FAULT: f_valid=1, f_exception=1, f_ecause=1, f_pc=f_etval=fault address. No requests until redirect.
- Buffer write:
  - First response after a redirect to an addr with bit1=1 writes only rdata[31:16], so count += 1.
  - Otherwise rdata[15:0] then rdata[31:16] are appended, so count += 2.
- Output alignment (combinational from buffer head):
  - head[1:0]≠2'b11 and count≥1: 16-bit instruction.
  - head[1:0]=2'b11 and count≥2: 32-bit instruction, {head+1, head}.
  - 32-bit with count=1: f_valid=0 (straddles words; wait for next response).
- Consume: f_valid & !stall & !redirect & !f_exception.
  - Pops 1 or 2 halfwords.
  - pc += 2 or 4; 32-bit arithmetic, wraps at 2^32.
  - A simultaneous write and pop in the same cycle is legal; count updates by the net amount.
- Redirect (priority over everything):
  - Next cycle: count=0, pc=redirect_addr, fetch_addr=redirect_addr&~3, state FETCH.
  - If a request is outstanding, the state stays WAIT with drop=1; the new fetch starts after the old response arrives.
  - redirect_addr[0]=1: enter FAULT with ecause=0, etval=redirect_addr, and issue no request.
  - f_valid=0 in the cycle after redirect.
- Latency: redirect to first f_valid is 3 cycles with zero-wait memory and no drop (request, response, buffer).
- Stall holds all f_* stable; fetching continues until the buffer is full.
- Reset mid-request: internal state clears immediately and any later imem_ready is ignored (drop not needed, state FETCH issues a fresh request).

Test Plan:
- Reset, RESET_ADDR=0x80, zero-wait memory returning 0x00000013 → imem_addr=0x80; f_valid with f_pc=0x80, 0x84, 0x88, f_instr=0x13.
- Memory word 0x45014501 (two c.li) then 0x00000013 → f_pc 0x0 (instr 0x4501), 0x2 (0x4501), 0x4 (0x13).
- Redirect to 0x102 with word@0x100=0x00134501 and word@0x104=0x00000013 → first request 0x100; 32-bit instr 0x00000013... formed as {0x0013 from 0x104 lo, 0x0013 from 0x102}, i.e. f_instr=0x00130013 at f_pc=0x102, valid only after the second response.
- Redirect while a request is outstanding, stale response 0xDEADBEEF → stale data never reaches f_instr; next imem_addr = new target.
- stall=1 for 10 cycles with 16-bit instrs → count saturates at BUF_DEPTH, imem_valid stays 0, f_* held; release → consecutive pcs +2 with no gap.
- imem_error on address 0x200 → f_exception=1, f_ecause=1, f_etval=0x200, no further imem_valid until redirect; redirect to 0x301 → f_ecause=0, f_etval=0x301.
